// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard: slot entry layout,
// select encoding and issue latency classes.
package fwd_pkg;

    // Entry fields are sized for the widest supported configuration; narrower
    // register/latency widths are zero-extended into them.
    localparam int ENT_RD_W  = 8;
    localparam int ENT_CNT_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [ENT_RD_W-1:0]  rd;
        logic [ENT_CNT_W-1:0] cnt;
    } fwd_entry_t;

    localparam int FWD_RF   = 0;
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand: youngest matching in-flight write
// decides between forwarding from its slot and requesting a stall.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int REG_AW    = 5,
    parameter int SELW      = 2
) (
    input  fwd_entry_t [FWD_DEPTH-1:0] slots,
    input  logic                       src_valid,
    input  logic [REG_AW-1:0]          src_addr,
    output logic [SELW-1:0]            sel,
    output logic                       stall_req
);

    logic found;

    // Scan from slot 0 upward; the first hit is the youngest producer and
    // masks every older slot, ready or not.
    always_comb begin
        sel       = SELW'(FWD_RF);
        stall_req = 1'b0;
        found     = 1'b0;
        if (src_valid && (src_addr != '0)) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                if (!found && slots[k].valid && (slots[k].rd == ENT_RD_W'(src_addr))) begin
                    found = 1'b1;
                    if (slots[k].cnt == '0) begin
                        sel = SELW'(k + 1);
                    end else begin
                        stall_req = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Scoreboard of in-flight register writes with per-write latency; drives the
// operand forwarding selects, the decode stall and a saturating stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 3,
    parameter int REG_AW    = 5,
    parameter int LAT_W     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid,
    input  logic                                 issue_wen,
    input  logic [REG_AW-1:0]                    issue_rd,
    input  logic [LAT_W-1:0]                     issue_lat,
    input  logic                                 flush,
    input  logic [NUM_SRC-1:0]                   src_valid,
    input  logic [NUM_SRC*REG_AW-1:0]            src_addr,
    output logic [NUM_SRC*sel_w(FWD_DEPTH)-1:0]  fwd_sel,
    output logic                                 stall,
    output logic [CNT_W-1:0]                     stall_cnt
);

    localparam int SELW = sel_w(FWD_DEPTH);

    fwd_entry_t [FWD_DEPTH-1:0] slots;
    fwd_entry_t                 new_entry;
    logic [NUM_SRC-1:0]         stall_req;
    logic                       load_en;
    int                         lat_eff;

    function automatic fwd_entry_t age(input fwd_entry_t e);
        fwd_entry_t r;
        r = e;
        if (e.cnt != '0) begin
            r.cnt = e.cnt - ENT_CNT_W'(1);
        end
        return r;
    endfunction

    // A stalled decode never enters the scoreboard; flush beats a same-cycle issue.
    assign load_en = issue_valid & ~stall & issue_wen & (issue_rd != '0) & ~flush;

    always_comb begin
        lat_eff = int'(issue_lat);
        if (lat_eff < LAT_ALU) begin
            lat_eff = LAT_ALU;
        end
        if (lat_eff > FWD_DEPTH) begin
            lat_eff = FWD_DEPTH;
        end
        new_entry       = '0;
        new_entry.valid = load_en;
        if (load_en) begin
            new_entry.rd  = ENT_RD_W'(issue_rd);
            new_entry.cnt = ENT_CNT_W'(lat_eff - 1);
        end
    end

    // Slot shift register: slot 0 takes the new issue or a bubble, the last slot retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots     <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                slots <= '0;
            end else begin
                slots[0] <= new_entry;
                for (int k = 1; k < FWD_DEPTH; k++) begin
                    slots[k] <= age(slots[k-1]);
                end
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .REG_AW    (REG_AW),
            .SELW      (SELW)
        ) u_match (
            .slots     (slots),
            .src_valid (src_valid[s]),
            .src_addr  (src_addr[s*REG_AW +: REG_AW]),
            .sel       (fwd_sel[s*SELW +: SELW]),
            .stall_req (stall_req[s])
        );
    end

    assign stall = |stall_req;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed scoreboard bench for fwd_scoreboard: default instance plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_wen, flush;
    logic [4:0] issue_rd;
    logic [1:0] issue_lat;
    logic [1:0] src_valid;
    logic [9:0] src_addr;
    logic [3:0] fwd_sel, fwd_sel_s;
    logic       stall, stall_s;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_s;

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
        .src_valid(src_valid), .src_addr(src_addr),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
        .src_valid(src_valid), .src_addr(src_addr),
        .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
    );

    typedef struct {
        string tag;
        int    sel0;
        int    sel1;
        bit    stall;
        int    cnt;
        int    cnt2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;
    bit   last_stall = 1'b0;

    task automatic drive(input bit iv, input bit wen, input int rd, input int lat, input bit fl,
                         input bit v0, input int a0, input bit v1, input int a1);
        issue_valid = iv;
        issue_wen   = wen;
        issue_rd    = 5'(rd);
        issue_lat   = 2'(lat);
        flush       = fl;
        src_valid   = {v1, v0};
        src_addr    = {5'(a1), 5'(a0)};
    endtask

    task automatic expect_out(input string tag, input int s0, input int s1, input bit st);
        exp_t e;
        e.tag   = tag;
        e.sel0  = s0;
        e.sel1  = s1;
        e.stall = st;
        e.cnt   = exp_cnt;
        e.cnt2  = exp_cnt2;
        sb.push_back(e);
        last_stall = st;
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed 0 entries expected at least 1");
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checks++;
        assert (32'(fwd_sel[1:0]) === 32'(e.sel0)) else begin
            errors++;
            $error("FAIL %s.sel0 observed %0d expected %0d", e.tag, fwd_sel[1:0], e.sel0);
        end
        checks++;
        assert (32'(fwd_sel[3:2]) === 32'(e.sel1)) else begin
            errors++;
            $error("FAIL %s.sel1 observed %0d expected %0d", e.tag, fwd_sel[3:2], e.sel1);
        end
        checks++;
        assert (stall === e.stall) else begin
            errors++;
            $error("FAIL %s.stall observed %b expected %b", e.tag, stall, e.stall);
        end
        checks++;
        assert (32'(stall_cnt) === 32'(e.cnt)) else begin
            errors++;
            $error("FAIL %s.stall_cnt observed %0d expected %0d", e.tag, stall_cnt, e.cnt);
        end
        checks++;
        assert (stall_s === e.stall) else begin
            errors++;
            $error("FAIL %s.stall_sat observed %b expected %b", e.tag, stall_s, e.stall);
        end
        checks++;
        assert (32'(stall_cnt_s) === 32'(e.cnt2)) else begin
            errors++;
            $error("FAIL %s.stall_cnt_sat observed %0d expected %0d", e.tag, stall_cnt_s, e.cnt2);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (last_stall) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        #1;
    endtask

    task automatic cyc(input string tag, input bit iv, input bit wen, input int rd, input int lat,
                       input bit fl, input bit v0, input int a0, input bit v1, input int a1,
                       input int s0, input int s1, input bit st);
        drive(iv, wen, rd, lat, fl, v0, a0, v1, a1);
        expect_out(tag, s0, s1, st);
        #3;
        check_out();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        expect_out("reset", 0, 0, 0);
        check_out();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU result forwards from slot 0, then 1, then 2, then retires
        cyc("alu_issue",   1, 1, 5, LAT_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("alu_fwd0",    0, 0, 0, 0,       0, 1, 5, 0, 0, 1, 0, 0);
        cyc("alu_fwd1",    0, 0, 0, 0,       0, 1, 5, 0, 0, 2, 0, 0);
        cyc("alu_fwd2",    0, 0, 0, 0,       0, 1, 5, 0, 0, 3, 0, 0);
        cyc("alu_retired", 0, 0, 0, 0,       0, 1, 5, 0, 0, 0, 0, 0);

        // load-use: one stall cycle then forward from slot 1
        cyc("ld_issue", 1, 1, 7, LAT_LOAD, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("ld_stall", 0, 0, 0, 0,        0, 0, 0, 1, 7, 0, 0, 1);
        cyc("ld_fwd",   0, 0, 0, 0,        0, 0, 0, 1, 7, 0, 2, 0);

        // youngest not-ready producer wins over an older ready one; issue ignored while stalled
        cyc("yw_alu",   1, 1, 3,  LAT_ALU,  0, 0, 0, 0, 0,  0, 0, 0);
        cyc("yw_load",  1, 1, 3,  LAT_LOAD, 0, 0, 0, 0, 0,  0, 0, 0);
        cyc("yw_stall", 1, 1, 11, LAT_ALU,  0, 1, 3, 0, 0,  0, 0, 1);
        cyc("yw_after", 0, 0, 0,  0,        0, 1, 3, 1, 11, 2, 0, 0);

        // x0 never tracked, disabled sources never match
        cyc("x0_issue", 1, 1, 0, LAT_ALU, 0, 1, 0, 0, 3, 0, 0, 0);
        cyc("x0_src",   0, 0, 0, 0,       0, 1, 0, 0, 3, 0, 0, 0);

        // latency 0 is clamped to ALU latency
        cyc("clamp_issue", 1, 1, 14, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc("clamp_fwd",   0, 0, 0,  0, 0, 1, 14, 0, 0, 1, 0, 0);

        // flush kills both in-flight entries and a simultaneous issue
        cyc("fl_issue", 1, 1, 9, LAT_ALU, 1, 0, 0, 0, 0,  0, 0, 0);
        cyc("fl_src",   0, 0, 0, 0,       0, 1, 9, 1, 14, 0, 0, 0);

        // asynchronous reset during a load-use stall
        cyc("rs_issue", 1, 1, 7, LAT_LOAD, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
        expect_out("rs_stall", 0, 0, 1);
        #3;
        check_out();
        rst = 1'b1;
        #1;
        exp_cnt  = 0;
        exp_cnt2 = 0;
        expect_out("rs_async", 0, 0, 0);
        check_out();
        #1;
        rst = 1'b0;
        advance();
        cyc("rs_release", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);

        // latency-3 producers repeatedly: five stall cycles saturate the 2-bit counter
        for (int c = 0; c < 8; c++) begin
            cyc($sformatf("sat%0d", c), 1, 1, 20, 3, 0, 1, 20, 0, 0,
                (c != 0 && (c % 3) == 0) ? 3 : 0, 0, (c % 3) != 0);
        end
        cyc("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the RISC-V pipeline. It replaces fixed EX/MEM and MEM/WB comparisons with a shift-register scoreboard of in-flight register writes. Each write carries its own result latency. For every decode-stage source operand, the block chooses the youngest ready producer stage to forward from, or raises a stall when the producer is not ready yet. It sits between decode and the register-file/EX operand muxes and also counts stall cycles for performance monitoring.

## Interface
Parameters:
- NUM_SRC, 2: number of source operands checked per cycle.
- FWD_DEPTH, 3: number of post-issue pipeline slots that can forward (slot 0 = EX output).
- REG_AW, 5: register address width.
- LAT_W, 2: width of the issue latency field.
- CNT_W, 16: width of the stall counter.

Ports (SELW = clog2(FWD_DEPTH+1)):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  the decode instruction advances into EX this cycle.
- issue_wen  in  1  the issuing instruction writes a register.
- issue_rd  in  REG_AW  destination register of the issuing instruction.
- issue_lat  in  LAT_W  cycles until the result is forwardable (1 = ALU, 2 = load).
- flush  in  1  synchronous pipeline-wide kill of all in-flight entries.
- src_valid  in  NUM_SRC  per-source "operand used".
- src_addr  in  NUM_SRC*REG_AW  source register addresses, packed with source 0 in the LSBs.
- fwd_sel  out  NUM_SRC*SELW  per-source select: 0 = register file, k+1 = slot k.
- stall  out  1  hold decode; insert a bubble into slot 0.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Entry state per slot: valid, rd, cnt (LAT_W bits).
- Slots shift each cycle: slot k moves to slot k+1. Slot FWD_DEPTH-1 retires, because writeback is complete and the register file holds the value.
- Slot 0 load rule:
  - An entry is loaded when issue_valid & ~stall & issue_wen & issue_rd≠0 & ~flush.
  - The loaded entry is {1, issue_rd, L-1}, where L is issue_lat clamped to the range [1, FWD_DEPTH].
  - Otherwise slot 0 loads a bubble (valid=0).
- cnt decrements by one per shift and saturates at 0.
- A slot is ready when cnt==0.
- Per-source match, evaluated only when src_valid=1 and src_addr≠0:
  - Find the lowest-index slot k with valid & rd==src_addr (the youngest producer).
  - If that slot is ready, fwd_sel=k+1.
  - If it is not ready, fwd_sel=0 and that source requests a stall.
  - If no slot matches, fwd_sel=0.
  - An older ready match never overrides a younger not-ready match.
- stall is the OR of all per-source stall requests.
- While stall=1, issue_valid is ignored.
- flush=1 clears every valid bit at the next edge. flush wins over a simultaneous issue.
- stall_cnt increments on each edge where stall=1 and saturates at all ones. flush does not clear it.

## Timing
- fwd_sel and stall are combinational from the registered slots and the src_* inputs. There are no registered outputs except stall_cnt.
- An ALU result issued at edge t is forwardable from slot 0 in cycle t+1, with zero stall.
- A load (L=2) issued at t is in slot 0 with cnt=1 in cycle t+1, so a dependent instruction stalls one cycle. At t+2 the load is in slot 1, ready, and fwd_sel=2.
- Entries are visible for FWD_DEPTH cycles after issue, then they retire.
- Reset values: all valid=0, rd=0, cnt=0, stall_cnt=0. Hence fwd_sel=0 and stall=0.
- If reset is asserted mid-operation, all entries are dropped immediately. There is no stall after reset release.

## Structure
- Shared package fwd_pkg holds:
  - the entry struct type (valid, rd, cnt);
  - the FWD_RF=0 select constant;
  - the clog2-based SELW helper;
  - latency constants LAT_ALU=1 and LAT_LOAD=2.
- Sub-module fwd_match is a priority matcher for one source. It takes the slot array plus src_valid/src_addr and returns sel and stall_req. It is instantiated NUM_SRC times through a generate loop.
- The top level holds the slot shift register, the issue/flush logic and the stall counter.

## Test plan
- ALU back-to-back: issue rd=5 with lat=1, then src0=5 the next cycle. Required: fwd_sel0=1, stall=0. One cycle later: fwd_sel0=2. After FWD_DEPTH cycles: fwd_sel0=0.
- Load-use: issue rd=7 with lat=2, then src1=7. Required: stall=1 for exactly one cycle and stall_cnt=1, then fwd_sel1=2 with stall=0.
- Youngest wins: issue rd=3 (ALU) at t, then rd=3 (load) at t+1, then src0=3 at t+2. Required: stall=1, even though slot 1 holds a ready rd=3.
- x0 and disabled sources: issue rd=0; also drive src_valid=0 with a matching address. Required: fwd_sel=0 and stall=0 in all cycles.
- Flush with issue: issue rd=9 in the same cycle as flush=1, then src0=9. Required: fwd_sel0=0, stall=0, and stall_cnt unchanged.
- Reset mid-stall and counter saturation:
  - Assert rst asynchronously during a load-use stall. Required: stall drops immediately and all outputs are 0.
  - With CNT_W=2, hold a stall condition for 5 cycles. Required: stall_cnt saturates at 3.
